// File: rtl/pc_fetch_gen_if.sv
// Fetch request bus between the PC generator and the instruction cache.
// The generator drives the request (valid, block address, slot mask) and
// the cache answers with ready.
interface pc_fetch_gen_if #(
   parameter int ADDR_W  = 32,
   parameter int FETCH_W = 2
);

   logic              req_valid_o;
   logic              req_ready_i;
   logic [ADDR_W-1:0] req_addr_o;
   logic [FETCH_W-1:0] fetch_mask_o;

   modport master (
      output req_valid_o,
      output req_addr_o,
      output fetch_mask_o,
      input  req_ready_i
   );

   modport slave (
      input  req_valid_o,
      input  req_addr_o,
      input  fetch_mask_o,
      output req_ready_i
   );

endinterface

// File: rtl/pc_fetch_gen.sv
// Next-PC / fetch-request generator for the front end.
// Issues one fetch block of FETCH_W instructions per accepted request,
// applies flush and branch redirects (flush wins), and parks a redirect
// that arrives while a request is stalled so the stalled address stays
// stable until the icache takes it.
module pc_fetch_gen #(
   parameter int                ADDR_W   = 32,
   parameter int                FETCH_W  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h1c000000),
   parameter int                PAUSE_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PAUSE_W-1:0] pause,
   input  logic               flush_i,
   input  logic [ADDR_W-1:0]  flush_target_i,
   input  logic               branch_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   pc_fetch_gen_if.master     bus,
   output logic [ADDR_W-1:0]  pc_o
);

   // Byte size of one fetch block and the mask of the in-block offset bits.
   localparam logic [ADDR_W-1:0] BLOCK_BYTES = ADDR_W'(FETCH_W * 4);
   localparam logic [ADDR_W-1:0] OFF_MASK    = ADDR_W'(FETCH_W * 4 - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK   = ADDR_W'(3);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_d;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_d;

   logic              pending_valid;
   logic              pending_is_flush;
   logic [ADDR_W-1:0] pending_target;
   logic              pending_valid_d;
   logic              pending_is_flush_d;
   logic [ADDR_W-1:0] pending_target_d;

   logic              merged_valid;
   logic              merged_is_flush;
   logic [ADDR_W-1:0] merged_target;

   logic [ADDR_W-1:0] flush_tgt;
   logic [ADDR_W-1:0] branch_tgt;
   logic [ADDR_W-1:0] seq_next;
   logic [ADDR_W-1:0] slot_idx;
   logic              req_valid;
   logic              fire;

   // Only the fetch-stage bit of the pause vector matters to this block.
   logic unused_pause;
   assign unused_pause = ^pause;

   // Redirect targets are word aligned; the low two bits are dropped.
   assign flush_tgt  = flush_target_i  & ~WORD_MASK;
   assign branch_tgt = branch_target_i & ~WORD_MASK;

   // Next sequential block: align down to the block base and step one
   // block; the adder wraps naturally at the top of the address space.
   assign seq_next = (pc & ~OFF_MASK) + BLOCK_BYTES;
   assign slot_idx = (pc & OFF_MASK) >> 2;

   // Slot mask marks every slot at or after the one the PC points into.
   always_comb begin
      bus.fetch_mask_o = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         bus.fetch_mask_o[i] = (ADDR_W'(i) >= slot_idx);
      end
   end

   // Request valid depends only on state and redirect/pause inputs, never
   // on ready, so no combinational loop can form through the icache.
   always_comb begin
      req_valid = 1'b0;
      case (state)
         ST_RUN:  req_valid = !pause[0] && !flush_i && !branch_i;
         ST_WAIT: req_valid = 1'b1;
         default: req_valid = 1'b0;
      endcase
   end

   assign fire             = req_valid && bus.req_ready_i;
   assign bus.req_valid_o  = req_valid;
   assign bus.req_addr_o   = pc;
   assign pc_o             = pc;

   // Fold this cycle's redirect into the parked one: a flush always
   // overwrites, a parked flush is never displaced by a branch, and a
   // branch otherwise replaces whatever branch was parked.
   always_comb begin
      merged_valid    = pending_valid;
      merged_is_flush = pending_is_flush;
      merged_target   = pending_target;
      if (flush_i) begin
         merged_valid    = 1'b1;
         merged_is_flush = 1'b1;
         merged_target   = flush_tgt;
      end else if (pending_valid && pending_is_flush) begin
         merged_valid    = 1'b1;
         merged_is_flush = 1'b1;
         merged_target   = pending_target;
      end else if (branch_i) begin
         merged_valid    = 1'b1;
         merged_is_flush = 1'b0;
         merged_target   = branch_tgt;
      end
   end

   // Next-state and next-PC selection for the IDLE/RUN/WAIT controller.
   always_comb begin
      state_d            = state;
      pc_d               = pc;
      pending_valid_d    = pending_valid;
      pending_is_flush_d = pending_is_flush;
      pending_target_d   = pending_target;
      case (state)
         ST_IDLE: begin
            state_d = ST_RUN;
            if (flush_i) begin
               pc_d = flush_tgt;
            end else if (branch_i) begin
               pc_d = branch_tgt;
            end
         end
         ST_RUN: begin
            if (flush_i) begin
               pc_d = flush_tgt;
            end else if (branch_i) begin
               pc_d = branch_tgt;
            end else if (fire) begin
               pc_d = seq_next;
            end else if (req_valid) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.req_ready_i) begin
               pc_d               = merged_valid ? merged_target : seq_next;
               pending_valid_d    = 1'b0;
               pending_is_flush_d = 1'b0;
               state_d            = ST_RUN;
            end else begin
               pending_valid_d    = merged_valid;
               pending_is_flush_d = merged_is_flush;
               pending_target_d   = merged_target;
            end
         end
         default: begin
            state_d            = ST_IDLE;
            pending_valid_d    = 1'b0;
            pending_is_flush_d = 1'b0;
         end
      endcase
   end

   // State, PC and parked-redirect registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         pc               <= RESET_PC;
         pending_valid    <= 1'b0;
         pending_is_flush <= 1'b0;
         pending_target   <= '0;
      end else begin
         state            <= state_d;
         pc               <= pc_d;
         pending_valid    <= pending_valid_d;
         pending_is_flush <= pending_is_flush_d;
         pending_target   <= pending_target_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed scenarios followed by a
// randomized run, all compared against a block-arithmetic reference model.
module tb_pc_fetch_gen;

   localparam int          ADDR_W   = 32;
   localparam int          FETCH_W  = 2;
   localparam int          PAUSE_W  = 6;
   localparam logic [31:0] RESET_PC = 32'h1c000000;
   localparam longint unsigned BLK  = FETCH_W * 4;
   localparam longint unsigned SPAN = 64'h1_0000_0000;

   logic               clk = 1'b0;
   logic               rst;
   logic [PAUSE_W-1:0] pause;
   logic               flush_i;
   logic [ADDR_W-1:0]  flush_target_i;
   logic               branch_i;
   logic [ADDR_W-1:0]  branch_target_i;
   logic [ADDR_W-1:0]  pc_o;

   int checks   = 0;
   int failures = 0;

   // Reference model: phase 0 = just out of reset, 1 = issuing, 2 = stalled.
   longint unsigned m_pc;
   int              m_phase;
   bit              m_pend;
   bit              m_pend_flush;
   longint unsigned m_pend_tgt;

   pc_fetch_gen_if #(.ADDR_W(ADDR_W), .FETCH_W(FETCH_W)) bus ();

   pc_fetch_gen #(
      .ADDR_W  (ADDR_W),
      .FETCH_W (FETCH_W),
      .RESET_PC(RESET_PC),
      .PAUSE_W (PAUSE_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pause          (pause),
      .flush_i        (flush_i),
      .flush_target_i (flush_target_i),
      .branch_i       (branch_i),
      .branch_target_i(branch_target_i),
      .bus            (bus),
      .pc_o           (pc_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic longint unsigned wordAlign(input longint unsigned a);
      return a - (a % 4);
   endfunction

   function automatic longint unsigned nextBlock(input longint unsigned a);
      return (((a / BLK) + 1) * BLK) % SPAN;
   endfunction

   function automatic logic [FETCH_W-1:0] slotMask(input longint unsigned a);
      logic [FETCH_W-1:0] m;
      longint unsigned    first;
      first = (a % BLK) / 4;
      for (int i = 0; i < FETCH_W; i++) m[i] = (i >= first);
      return m;
   endfunction

   function automatic bit expValid(input bit p0, input bit f, input bit b);
      if (m_phase == 1) return !p0 && !f && !b;
      return m_phase == 2;
   endfunction

   task automatic modelReset();
      m_pc         = RESET_PC;
      m_phase      = 0;
      m_pend       = 0;
      m_pend_flush = 0;
      m_pend_tgt   = 0;
   endtask

   // One clock of the reference behaviour, evaluated on the inputs of that cycle.
   task automatic modelStep(input bit r, input bit p0, input bit f, input longint unsigned ft,
                            input bit b, input longint unsigned bt, input bit rdy);
      bit v;
      v = expValid(p0, f, b);
      if (r) begin
         modelReset();
      end else if (m_phase == 2) begin
         if (f) begin
            m_pend = 1; m_pend_flush = 1; m_pend_tgt = wordAlign(ft);
         end else if (!(m_pend && m_pend_flush) && b) begin
            m_pend = 1; m_pend_flush = 0; m_pend_tgt = wordAlign(bt);
         end
         if (rdy) begin
            m_pc         = m_pend ? m_pend_tgt : nextBlock(m_pc);
            m_pend       = 0;
            m_pend_flush = 0;
            m_phase      = 1;
         end
      end else begin
         if (f) m_pc = wordAlign(ft);
         else if (b) m_pc = wordAlign(bt);
         else if (m_phase == 1 && v && rdy) m_pc = nextBlock(m_pc);
         else if (m_phase == 1 && v) m_phase = 2;
         if (m_phase == 0) m_phase = 1;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check outputs, clock it.
   task automatic applyStimulus(input string tag, input bit r, input bit p0,
                                input bit f, input logic [31:0] ft,
                                input bit b, input logic [31:0] bt, input bit rdy);
      logic [31:0] rnd;
      rnd             = $urandom;
      rst             = r;
      pause           = {rnd[PAUSE_W-2:0], p0};
      flush_i         = f;
      flush_target_i  = ft;
      branch_i        = b;
      branch_target_i = bt;
      bus.req_ready_i = rdy;
      #1;
      checkOutput({tag, "_valid"}, 64'(bus.req_valid_o), 64'(expValid(p0, f, b)));
      checkOutput({tag, "_addr"},  64'(bus.req_addr_o),  m_pc);
      checkOutput({tag, "_mask"},  64'(bus.fetch_mask_o), 64'(slotMask(m_pc)));
      checkOutput({tag, "_pc"},    64'(pc_o),            m_pc);
      @(posedge clk);
      modelStep(r, p0, f, ft, b, bt, rdy);
      @(negedge clk);
   endtask

   task automatic expectAddr(input string tag, input logic [31:0] addr,
                             input logic [FETCH_W-1:0] mask);
      checkOutput(tag, 64'(bus.req_addr_o), 64'(addr));
      checkOutput({tag, "_mask"}, 64'(bus.fetch_mask_o), 64'(mask));
   endtask

   initial begin
      rst             = 1'b1;
      pause           = '0;
      flush_i         = 1'b0;
      flush_target_i  = '0;
      branch_i        = 1'b0;
      branch_target_i = '0;
      bus.req_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      modelReset();

      // Reset held for three cycles, then the IDLE cycle and sequential fetch.
      for (int i = 0; i < 3; i++) applyStimulus("reset", 1, 0, 0, 0, 0, 0, 1);
      expectAddr("rst_pc", 32'h1c000000, 2'b11);
      applyStimulus("idle", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("seq0", 32'h1c000000, 2'b11);
      applyStimulus("seq", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("seq1", 32'h1c000008, 2'b11);
      applyStimulus("seq", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("seq2", 32'h1c000010, 2'b11);

      // Misaligned branch target lands mid-block.
      applyStimulus("br", 0, 0, 0, 0, 1, 32'h1c000106, 1);
      expectAddr("br_mis", 32'h1c000104, 2'b10);
      applyStimulus("brfire", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("br_seq", 32'h1c000108, 2'b11);

      // Stalled request with branch, flush, branch parked behind it.
      applyStimulus("stall", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("wbr", 0, 0, 0, 0, 1, 32'h1c000200, 0);
      expectAddr("wait_hold", 32'h1c000108, 2'b11);
      applyStimulus("wfl", 0, 0, 1, 32'h1c000800, 0, 0, 0);
      applyStimulus("wbr2", 0, 0, 0, 0, 1, 32'h1c000300, 0);
      applyStimulus("wacc", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("wait_flush", 32'h1c000800, 2'b11);
      applyStimulus("stall", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("wbr", 0, 0, 0, 0, 1, 32'h1c000200, 0);
      applyStimulus("wbr2", 0, 0, 0, 0, 1, 32'h1c000300, 0);
      applyStimulus("wacc", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("wait_branch", 32'h1c000300, 2'b11);

      // Pause in RUN holds the PC; pause in WAIT is ignored.
      for (int i = 0; i < 4; i++) applyStimulus("pause", 0, 1, 0, 0, 0, 0, 1);
      expectAddr("pause_hold", 32'h1c000300, 2'b11);
      applyStimulus("unpause", 0, 0, 0, 0, 0, 0, 1);
      applyStimulus("stall", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("wpause", 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("wpacc", 0, 1, 0, 0, 0, 0, 1);
      expectAddr("wpause_next", 32'h1c000310, 2'b11);

      // Address wrap and simultaneous redirects.
      applyStimulus("brtop", 0, 0, 0, 0, 1, 32'hfffffff8, 1);
      expectAddr("top", 32'hfffffff8, 2'b11);
      applyStimulus("wrapfire", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("wrap", 32'h00000000, 2'b11);
      applyStimulus("both", 0, 0, 1, 32'h1c000400, 1, 32'h1c000500, 1);
      expectAddr("flush_wins", 32'h1c000400, 2'b11);

      // Reset while a flush is parked behind a stalled request.
      applyStimulus("stall", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("wfl", 0, 0, 1, 32'h1c000900, 0, 0, 0);
      applyStimulus("wrst", 1, 0, 0, 0, 0, 0, 0);
      expectAddr("wrst_pc", 32'h1c000000, 2'b11);
      applyStimulus("idle", 0, 0, 0, 0, 0, 0, 1);
      applyStimulus("post", 0, 0, 0, 0, 0, 0, 1);
      expectAddr("post_seq", 32'h1c000008, 2'b11);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] ft;
         logic [31:0] bt;
         ft = ($urandom_range(0, 7) == 0) ? $urandom : RESET_PC + $urandom_range(0, 4095);
         bt = ($urandom_range(0, 7) == 0) ? $urandom : RESET_PC + $urandom_range(0, 4095);
         applyStimulus("rand",
                       $urandom_range(0, 63) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 15) == 0, ft,
                       $urandom_range(0, 7) == 0, bt,
                       $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
Parametrised next-generation PC / fetch-request generator for the front end. It issues fetch blocks of FETCH_W instructions to the instruction cache over a valid/ready handshake. It applies flush and branch redirects with fixed priority and buffers a redirect that arrives while a request is stalled. It sits between the redirect sources (back-end flush, branch unit), the stall controller and the icache request port.

Parameters:
ADDR_W, 32, PC/address width in bits
FETCH_W, 2, instructions per fetch block; power of two, 1..8
RESET_PC, 32'h1c000000, PC after reset (ADDR_W bits, low 2 bits zero)
PAUSE_W, 6, width of pipeline pause vector; only bit 0 is used here

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
pause  in  PAUSE_W  stall vector; pause[0] stalls fetch issue
flush_i  in  1  exception/ertn/refetch redirect, highest priority
flush_target_i  in  ADDR_W  flush target PC
branch_i  in  1  branch-unit redirect
branch_target_i  in  ADDR_W  branch target PC
req_valid_o  out  1  fetch request valid
req_ready_i  in  1  icache accepts request
req_addr_o  out  ADDR_W  fetch block PC (= current pc)
fetch_mask_o  out  FETCH_W  valid slots in the fetch block
pc_o  out  ADDR_W  current PC register (debug/trace)

Behaviour:
- OFF = log2(FETCH_W)+2. Slot index = pc[OFF-1:2]. Redirect targets have bits [1:0] forced to 0.
- seq_next = {pc[ADDR_W-1:OFF]+1, OFF'b0}. Wraps modulo 2^ADDR_W, so the last block goes to 0. For FETCH_W=1, seq_next = pc+4.
- fetch_mask_o[i] = (i >= slot index). Combinational from pc. All ones when pc is block-aligned.
- req_addr_o = pc_o = pc register.
- fire = req_valid_o && req_ready_i.
- States: IDLE, RUN, WAIT.
- Reset (rst=1 at posedge, any state, including mid-WAIT): state=IDLE, pc=RESET_PC, pending_valid=0, pending_is_flush=0.
  - During and immediately after reset, req_valid_o=0 and fetch_mask_o reflects RESET_PC.
- IDLE: req_valid_o=0. Next cycle goes to RUN. Redirects in IDLE are applied to pc directly, same rule as RUN.
- RUN:
  - req_valid_o = !pause[0] && !flush_i && !branch_i.
  - If flush_i: pc<=flush target. Else if branch_i: pc<=branch target. No request issues that cycle.
  - Else if fire: pc<=seq_next.
  - Else if req_valid_o && !req_ready_i: go to WAIT, pc held.
  - Else (paused): pc held.
- WAIT:
  - req_valid_o=1 unconditionally; pause[0] is ignored. req_addr_o is held stable until accepted.
  - Redirects are merged into the pending register each cycle:
    - flush_i: pending <= flush target, is_flush=1.
    - else if pending is a flush: keep it.
    - else if branch_i: pending <= branch target, is_flush=0.
    - else: keep.
  - On req_ready_i=1, using the merged value including this cycle's inputs:
    - pc <= merged pending target if any, else seq_next.
    - pending cleared; state RUN.
  - The accepted request is wrong-path when a redirect was pending; the downstream flush discards it. This block takes no further action.
- Latency:
  - Redirect in RUN/IDLE appears on req_addr_o the next cycle.
  - Redirect in WAIT appears the cycle after acceptance.
  - First request is valid 2 cycles after rst is released (IDLE then RUN).
- No combinational path from req_ready_i to req_valid_o or req_addr_o.

Test Plan:
- Reset: FETCH_W=2, assert rst 3 cycles, ready=1. Expect req_valid_o=0 and pc_o=0x1c000000 during reset and the first cycle after. Then valid=1 with addrs 0x1c000000, 0x1c000008, 0x1c000010 on consecutive cycles, mask=2'b11.
- Misaligned branch: in RUN, branch_i=1, target 0x1c000106. Expect valid=0 that cycle. Next cycle addr=0x1c000104, mask=2'b10. After fire, addr=0x1c000108, mask=2'b11.
- Buffered redirect: ready=0 so WAIT holds addr A. branch_i (0x1c000200), then flush_i (0x1c000800), then branch_i (0x1c000300), then ready=1. Expect addr A stable throughout and next addr 0x1c000800. Repeat with only the branches: next addr 0x1c000300.
- Pause: pause[0]=1 in RUN for 4 cycles. Expect valid=0 and pc held. Release: same addr issues. pause[0]=1 while in WAIT: valid stays 1.
- Wrap and simultaneity: pc=0xFFFFFFF8, fire gives next addr 0x00000000. flush_i and branch_i together in RUN: flush target wins.
- Reset mid-WAIT: ready=0 with a pending flush, then rst. Expect IDLE, pc=RESET_PC, pending discarded; the first post-reset request is RESET_PC.
